// File: rtl/systolic_skew_feeder.sv
// Edge feeder for a ROWS x COLS output-stationary systolic array: skews A/B beats onto the array edges.
// Optional build macro FEEDER_STALL_CNT_EN enables the bubble-cycle counter behind stall_count.
module systolic_skew_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned K_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_a_vec,
    input  logic [COLS*DATA_WIDTH-1:0] in_b_vec,
    output logic                       load_bias,
    output logic [ROWS*DATA_WIDTH-1:0] edge_a,
    output logic [COLS*DATA_WIDTH-1:0] edge_b,
    output logic                       busy,
    output logic                       done,
    output logic [K_WIDTH-1:0]         stall_count
);

    localparam int unsigned FLUSH_CYC = ROWS + COLS - 1;
    localparam int unsigned FC_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BIAS,
        STREAM,
        FLUSH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [K_WIDTH-1:0] beats_left;
    logic [FC_W-1:0]   flush_cnt;
    logic              flush_last;
    logic              start_ok;
    logic              accept;
    logic              done_q;

    assign flush_last = (flush_cnt == FC_W'(FLUSH_CYC - 1));
    assign start_ok   = (state == IDLE) && start;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = BIAS;
            BIAS:    state_nxt = (beats_left == '0) ? FLUSH : STREAM;
            STREAM:  if (accept && (beats_left == K_WIDTH'(1))) state_nxt = FLUSH;
            FLUSH:   if (flush_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == STREAM) && (beats_left != '0);
        load_bias = (state == BIAS);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left <= '0;
        end else if (start_ok) begin
            beats_left <= k_len;
        end else if (accept) begin
            beats_left <= beats_left - K_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if ((state == FLUSH) && !flush_last) begin
            flush_cnt <= flush_cnt + FC_W'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

    // done is registered so it lands in the first IDLE cycle after the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FLUSH) && flush_last;
        end
    end

    assign done = done_q;

    // Lane r is stage 0 plus r delay registers; non-accept cycles inject zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane_a
        localparam int unsigned LAST = r;
        logic [DATA_WIDTH-1:0] sr [0:r];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned j = 0; j < LAST + 1; j++) begin
                    sr[j] <= '0;
                end
            end else begin
                sr[0] <= accept ? in_a_vec[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int unsigned j = 1; j < LAST + 1; j++) begin
                    sr[j] <= sr[j-1];
                end
            end
        end

        assign edge_a[r*DATA_WIDTH +: DATA_WIDTH] = sr[LAST];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lane_b
        localparam int unsigned LAST = c;
        logic [DATA_WIDTH-1:0] sr [0:c];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned j = 0; j < LAST + 1; j++) begin
                    sr[j] <= '0;
                end
            end else begin
                sr[0] <= accept ? in_b_vec[c*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int unsigned j = 1; j < LAST + 1; j++) begin
                    sr[j] <= sr[j-1];
                end
            end
        end

        assign edge_b[c*DATA_WIDTH +: DATA_WIDTH] = sr[LAST];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [K_WIDTH-1:0] stall_q;

    // Saturating; holds after done until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if ((state == STREAM) && in_ready && !in_valid && (stall_q != '1)) begin
            stall_q <= stall_q + K_WIDTH'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus queues expected outputs, a negedge monitor checks them.
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [R*DW-1:0] in_a_vec;
    logic [C*DW-1:0] in_b_vec;
    logic            load_bias;
    logic [R*DW-1:0] edge_a;
    logic [C*DW-1:0] edge_b;
    logic            busy;
    logic            done;
    logic [KW-1:0]   stall_count;

    systolic_skew_feeder #(
        .DATA_WIDTH(DW),
        .ROWS(R),
        .COLS(C),
        .K_WIDTH(KW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .k_len(k_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a_vec(in_a_vec),
        .in_b_vec(in_b_vec),
        .load_bias(load_bias),
        .edge_a(edge_a),
        .edge_b(edge_b),
        .busy(busy),
        .done(done),
        .stall_count(stall_count)
    );

    typedef enum int { K_EA, K_EB, K_LB, K_BUSY, K_RDY, K_STALL } kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        int          lane;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef FEEDER_STALL_CNT_EN
    localparam logic [15:0] BUBBLE_STALLS = 16'd1;
`else
    localparam logic [15:0] BUBBLE_STALLS = 16'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(kind_t k, int lane);
        case (k)
            K_EA:    return {8'h00, edge_a[lane*DW +: DW]};
            K_EB:    return {8'h00, edge_b[lane*DW +: DW]};
            K_LB:    return {15'd0, load_bias};
            K_BUSY:  return {15'd0, busy};
            K_RDY:   return {15'd0, in_ready};
            default: return stall_count;
        endcase
    endfunction

    // Monitor: consumes every expectation due this cycle, and every done pulse.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                logic [15:0] got;
                got = actual(exp_q[i].kind, exp_q[i].lane);
                checks++;
                if (got !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s lane %0d cycle %0d: got %h expected %h",
                             exp_q[i].kind.name(), exp_q[i].lane, cyc, got, exp_q[i].val);
                end
                exp_q.delete(i);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cycle %0d: got done=1 expected none", cyc);
            end else begin
                if (done_q[0] != cyc) begin
                    errors++;
                    $display("FAIL done_timing: got cycle %0d expected cycle %0d", cyc, done_q[0]);
                end
                void'(done_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic push(input int c, input kind_t k, input int lane, input logic [15:0] v);
        exp_t e;
        e.cyc = c; e.kind = k; e.lane = lane; e.val = v;
        exp_q.push_back(e);
    endtask

    // Beat accepted (or bubble slot) in cycle t: lane r shows it at t+1+r.
    task automatic exp_beat(input int t, input logic [31:0] a, input logic [31:0] b);
        for (int r = 0; r < R; r++) push(t + 1 + r, K_EA, r, {8'h00, a[r*DW +: DW]});
        for (int c = 0; c < C; c++) push(t + 1 + c, K_EB, c, {8'h00, b[c*DW +: DW]});
    endtask

    task automatic exp_quiet(input int c);
        push(c, K_BUSY, 0, 16'd0);
        push(c, K_RDY, 0, 16'd0);
        push(c, K_LB, 0, 16'd0);
        push(c, K_STALL, 0, 16'd0);
        for (int r = 0; r < R; r++) push(c, K_EA, r, 16'd0);
        for (int k = 0; k < C; k++) push(c, K_EB, k, 16'd0);
    endtask

    localparam logic [31:0] A0 = 32'h058A117F, B0 = 32'h3CFD8001;
    localparam logic [31:0] A1 = 32'hC3229E40, B1 = 32'h7E10EE02;
    localparam logic [31:0] A2 = 32'h01F05AA5, B2 = 32'h669933CC;
    localparam logic [31:0] JUNK = 32'hFFFFFFFF;

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        in_a_vec = '0; in_b_vec = '0;
        step(); step();
        rst = 1'b0;

        // Reset state, then a 2-beat tile
        exp_quiet(cyc);
        s = cyc;
        start = 1'b1; k_len = 16'd2;
        push(s + 1, K_LB, 0, 16'd1);
        push(s + 1, K_BUSY, 0, 16'd1);
        push(s + 1, K_RDY, 0, 16'd0);
        push(s + 1, K_EA, 3, 16'd0);
        push(s + 2, K_LB, 0, 16'd0);
        push(s + 2, K_RDY, 0, 16'd1);
        push(s + 3, K_RDY, 0, 16'd1);
        push(s + 4, K_RDY, 0, 16'd0);
        exp_beat(s + 2, A0, B0);
        exp_beat(s + 3, A1, B1);
        exp_beat(s + 4, 32'h0, 32'h0);
        done_q.push_back(s + 11);
        push(s + 11, K_BUSY, 0, 16'd0);
        push(s + 11, K_STALL, 0, 16'd0);
        step(); start = 1'b0; k_len = '0;
        step();
        in_valid = 1'b1; in_a_vec = A0; in_b_vec = B0; step();
        in_a_vec = A1; in_b_vec = B1; step();
        in_valid = 1'b0; in_a_vec = JUNK; in_b_vec = JUNK;
        go_to(s + 12);

        // Continuous 3-beat tile, ignored start at s+5, back-to-back zero-length tile at s+12
        s = cyc;
        start = 1'b1; k_len = 16'd3;
        push(s + 1, K_LB, 0, 16'd1);
        exp_beat(s + 2, A0, B0);
        exp_beat(s + 3, A1, B1);
        exp_beat(s + 4, A2, B2);
        push(s + 6, K_EA, 3, 16'h0005);
        push(s + 5, K_EB, 2, 16'h00FD);
        push(s + 6, K_BUSY, 0, 16'd1);
        push(s + 6, K_LB, 0, 16'd0);
        push(s + 6, K_RDY, 0, 16'd0);
        push(s + 12, K_EA, 3, 16'd0);
        push(s + 12, K_BUSY, 0, 16'd0);
        done_q.push_back(s + 12);
        step(); start = 1'b0; k_len = '0;
        step();
        in_valid = 1'b1; in_a_vec = A0; in_b_vec = B0; step();
        in_a_vec = A1; in_b_vec = B1; step();
        in_a_vec = A2; in_b_vec = B2; step();
        in_valid = 1'b0; in_a_vec = JUNK; in_b_vec = JUNK;
        start = 1'b1; k_len = 16'd7;
        step(); start = 1'b0; k_len = '0;
        go_to(s + 12);
        s = cyc;
        start = 1'b1; k_len = 16'd0;
        push(s + 1, K_LB, 0, 16'd1);
        push(s + 2, K_LB, 0, 16'd0);
        for (int i = 1; i <= 9; i++) push(s + i, K_RDY, 0, 16'd0);
        push(s + 8, K_BUSY, 0, 16'd1);
        push(s + 9, K_BUSY, 0, 16'd0);
        done_q.push_back(s + 9);
        step(); start = 1'b0;
        go_to(s + 10);

        // Bubble between two beats
        s = cyc;
        start = 1'b1; k_len = 16'd2;
        push(s + 3, K_RDY, 0, 16'd1);
        exp_beat(s + 2, A2, B2);
        exp_beat(s + 3, 32'h0, 32'h0);
        exp_beat(s + 4, A1, B1);
        push(s + 5, K_RDY, 0, 16'd0);
        done_q.push_back(s + 12);
        push(s + 12, K_STALL, 0, BUBBLE_STALLS);
        push(s + 14, K_STALL, 0, BUBBLE_STALLS);
        step(); start = 1'b0; k_len = '0;
        step();
        in_valid = 1'b1; in_a_vec = A2; in_b_vec = B2; step();
        in_valid = 1'b0; in_a_vec = JUNK; in_b_vec = JUNK; step();
        in_valid = 1'b1; in_a_vec = A1; in_b_vec = B1; step();
        in_valid = 1'b0; in_a_vec = JUNK; in_b_vec = JUNK;
        go_to(s + 15);

        // Reset after 2 of 5 beats
        s = cyc;
        start = 1'b1; k_len = 16'd5;
        push(s + 3, K_EA, 0, {8'h00, A0[7:0]});
        push(s + 4, K_EA, 1, {8'h00, A0[15:8]});
        push(s + 4, K_EB, 0, {8'h00, B1[7:0]});
        push(s + 4, K_BUSY, 0, 16'd1);
        push(s + 4, K_RDY, 0, 16'd1);
        exp_quiet(s + 5);
        exp_quiet(s + 12);
        step(); start = 1'b0; k_len = '0;
        step();
        in_valid = 1'b1; in_a_vec = A0; in_b_vec = B0; step();
        in_a_vec = A1; in_b_vec = B1; step();
        in_valid = 1'b0; in_a_vec = JUNK; in_b_vec = JUNK;
        rst = 1'b1; step(); rst = 1'b0;
        go_to(s + 25);
        @(negedge clk);

        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; errors++;
            $display("FAIL missed_%s lane %0d: cycle %0d never checked, expected %h",
                     exp_q[i].kind.name(), exp_q[i].lane, exp_q[i].cyc, exp_q[i].val);
        end
        for (int i = 0; i < done_q.size(); i++) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done, expected at cycle %0d", done_q[i]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
